trigger_sequencer: RTL and testbench

Register-programmed multi-pulse trigger generator for the glitch/fault-injection datapath. It watches `trigger_in` for a rising edge and emits a train of up to `NUM_PULSES` pulses on `trigger_out`, each with its own programmable delay and width. It supersedes the single delay/extend pair and sits on the command-handler register bus. Its `reg_data_out` is OR-combined with the other register slaves.

---
 rtl/trigger_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_trigger_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_sequencer.sv
// trigger_sequencer: register-programmed multi-pulse trigger generator.
// A rising edge on trigger_in starts a train of up to NUM_PULSES pulses on
// trigger_out. Each pulse has its own programmable delay and width.
// Build option: define TRIGSEQ_READBACK_EN to make NUM/DELAY/WIDTH readable.
// Without it, only STATUS reads back.
module trigger_sequencer #(
   parameter int         NUM_PULSES = 4,
   parameter int         CNT_BYTES  = 4,
   parameter logic [7:0] CMD_BASE   = 8'h20
) (
   input  logic        clkin,
   input  logic        reset,
   input  logic        trigger_in,
   input  logic [7:0]  reg_cmd,
   input  logic [15:0] reg_bytecount,
   input  logic [7:0]  reg_data_in,
   output logic [7:0]  reg_data_out,
   input  logic        reg_read,
   input  logic        reg_write,
   output logic        trigger_out
);
   localparam int         CNT_W     = 8 * CNT_BYTES;
   localparam int         LANE_BITS = $clog2(CNT_BYTES);
   localparam int         IDX_W     = (NUM_PULSES > 1) ? $clog2(NUM_PULSES) : 1;
   localparam logic [7:0] NUM_MAX   = 8'(NUM_PULSES);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DELAY, S_PULSE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] delay_tab [NUM_PULSES];
   logic [CNT_W-1:0] width_tab [NUM_PULSES];
   logic [7:0]       num_act;
   logic             auto_rearm;
   logic             done_r, done_nxt;
   logic [3:0]       idx, idx_nxt, idx_inc;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             cnt_last, more_pulses;
   logic             sync_p0, sync_p1, sync_p2, rise_p3;
   logic [7:0]       cmd_off, rd_val;
   logic [15:0]      entry, lane;
   logic             entry_ok, busy, armed;
   logic             wr_ctrl, wr_num, wr_delay, wr_width, rd_hit;
   logic             arm_req, abort_req;
   logic [IDX_W-1:0] entry_sel, cur_sel, next_sel;

   // NUM is held in 1..NUM_PULSES so the sequencer never sees 0 or an
   // index past the end of the tables.
   function automatic logic [7:0] clamp_num(input logic [7:0] v);
      if (v == 8'd0)
         return 8'd1;
      else if (v > NUM_MAX)
         return NUM_MAX;
      else
         return v;
   endfunction

`ifdef TRIGSEQ_READBACK_EN
   function automatic logic [7:0] pick_lane(input logic [CNT_W-1:0] w,
                                            input logic [15:0] ln);
      logic [7:0] r;
      r = 8'h00;
      for (int b = 0; b < CNT_BYTES; b++)
         if (ln == 16'(b)) r = w[b*8 +: 8];
      return r;
   endfunction
`endif

   // Register decode. Offsets are used so that a CMD_BASE near 8'hFF does not
   // wrap the range check.
   assign cmd_off   = reg_cmd - CMD_BASE;
   assign wr_ctrl   = reg_write && (cmd_off == 8'd0);
   assign wr_num    = reg_write && (cmd_off == 8'd1);
   assign wr_delay  = reg_write && (cmd_off == 8'd2);
   assign wr_width  = reg_write && (cmd_off == 8'd3);
   assign rd_hit    = reg_read && (cmd_off < 8'd4);
   assign arm_req   = wr_ctrl && reg_data_in[0];
   assign abort_req = wr_ctrl && reg_data_in[1];
   assign entry     = reg_bytecount >> LANE_BITS;
   assign lane      = reg_bytecount & 16'(CNT_BYTES - 1);
   assign entry_ok  = entry < 16'(NUM_PULSES);
   assign entry_sel = entry[IDX_W-1:0];

   assign busy        = (state == S_DELAY) || (state == S_PULSE);
   assign armed       = (state == S_ARMED);
   assign idx_inc     = idx + 4'd1;
   assign cur_sel     = idx[IDX_W-1:0];
   assign next_sel    = idx_inc[IDX_W-1:0];
   assign cnt_last    = (cnt[CNT_W-1:1] == '0);
   assign more_pulses = ({4'b0000, idx} + 8'd1) < num_act;

   // trigger_in synchroniser (p0/p1) followed by a registered edge detect (p3).
   always_ff @(posedge clkin) begin
      if (reset) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         sync_p2 <= 1'b0;
         rise_p3 <= 1'b0;
      end else begin
         sync_p0 <= trigger_in;
         sync_p1 <= sync_p0;
         sync_p2 <= sync_p1;
         rise_p3 <= sync_p1 & ~sync_p2;
      end
   end

   // Configuration registers. Table and NUM writes are frozen while a train runs.
   always_ff @(posedge clkin) begin
      if (reset) begin
         num_act    <= 8'd1;
         auto_rearm <= 1'b0;
         for (int i = 0; i < NUM_PULSES; i++) begin
            delay_tab[i] <= '0;
            width_tab[i] <= '0;
         end
      end else begin
         if (wr_ctrl)
            auto_rearm <= reg_data_in[2];
         if (wr_num && !busy)
            num_act <= clamp_num(reg_data_in);
         if ((wr_delay || wr_width) && !busy && entry_ok) begin
            for (int b = 0; b < CNT_BYTES; b++) begin
               if (lane == 16'(b)) begin
                  if (wr_delay)
                     delay_tab[entry_sel][b*8 +: 8] <= reg_data_in;
                  else
                     width_tab[entry_sel][b*8 +: 8] <= reg_data_in;
               end
            end
         end
      end
   end

   // Sequencer next-state logic. A zero first delay goes straight to PULSE
   // so the first pulse lands exactly DELAY[0] cycles after edge detection.
   // Later zero delays still spend one cycle in DELAY so pulses never merge.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      done_nxt  = done_r;
      case (state)
         S_IDLE: begin
            if (arm_req) begin
               state_nxt = S_ARMED;
               idx_nxt   = 4'd0;
               done_nxt  = 1'b0;
            end
         end
         S_ARMED: begin
            if (rise_p3) begin
               if (delay_tab[0] == '0) begin
                  state_nxt = S_PULSE;
                  cnt_nxt   = width_tab[0];
               end else begin
                  state_nxt = S_DELAY;
                  cnt_nxt   = delay_tab[0];
               end
            end
         end
         S_DELAY: begin
            if (cnt_last) begin
               state_nxt = S_PULSE;
               cnt_nxt   = width_tab[cur_sel];
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         S_PULSE: begin
            if (cnt_last) begin
               if (more_pulses) begin
                  state_nxt = S_DELAY;
                  idx_nxt   = idx_inc;
                  cnt_nxt   = delay_tab[next_sel];
               end else begin
                  done_nxt = 1'b1;
                  if (auto_rearm) begin
                     state_nxt = S_ARMED;
                     idx_nxt   = 4'd0;
                  end else begin
                     state_nxt = S_IDLE;
                  end
               end
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (abort_req) begin
         state_nxt = S_IDLE;
         idx_nxt   = idx;
         done_nxt  = done_r;
      end
   end

   // Sequencer state register. trigger_out mirrors the PULSE state and is
   // registered.
   always_ff @(posedge clkin) begin
      if (reset) begin
         state       <= S_IDLE;
         idx         <= 4'd0;
         cnt         <= '0;
         done_r      <= 1'b0;
         trigger_out <= 1'b0;
      end else begin
         state       <= state_nxt;
         idx         <= idx_nxt;
         cnt         <= cnt_nxt;
         done_r      <= done_nxt;
         trigger_out <= (state_nxt == S_PULSE);
      end
   end

   // Read mux. Its output is registered below.
   always_comb begin
      rd_val = 8'h00;
      case (cmd_off)
         8'd0: rd_val = {idx, 1'b0, done_r, busy, armed};
`ifdef TRIGSEQ_READBACK_EN
         8'd1: rd_val = num_act;
         8'd2: if (entry_ok) rd_val = pick_lane(delay_tab[entry_sel], lane);
         8'd3: if (entry_ok) rd_val = pick_lane(width_tab[entry_sel], lane);
`endif
         default: rd_val = 8'h00;
      endcase
   end

   // Registered read data. It is zero unless this block was read last cycle,
   // so it can be OR-ed with the other register slaves.
   always_ff @(posedge clkin) begin
      if (reset)
         reg_data_out <= 8'h00;
      else
         reg_data_out <= rd_hit ? rd_val : 8'h00;
   end
endmodule

// File: tb/tb_trigger_sequencer.sv
// Bench for trigger_sequencer. A train model turns the programmed table into
// the expected trigger_out cycles. A per-cycle monitor compares trigger_out
// and idle read data against that model. Directed register reads and
// literal pulse positions cover the rest.
module tb_trigger_sequencer;
   localparam int MAXC = 4096;

`ifdef TRIGSEQ_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   logic        clkin = 1'b0;
   logic        reset = 1'b1;
   logic        trigger_in = 1'b0;
   logic [7:0]  reg_cmd = 8'h00;
   logic [15:0] reg_bytecount = 16'h0000;
   logic [7:0]  reg_data_in = 8'h00;
   logic [7:0]  reg_data_out;
   logic        reg_read = 1'b0;
   logic        reg_write = 1'b0;
   logic        trigger_out;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int rd_label = -1;
   bit chk_en = 1'b0;
   bit exp_hi [0:MAXC-1];
   int pcount = 0;
   bit prev_to = 1'b0;

   longint m_delay [4];
   longint m_width [4];
   int     m_num;

   trigger_sequencer dut (
      .clkin        (clkin),
      .reset        (reset),
      .trigger_in   (trigger_in),
      .reg_cmd      (reg_cmd),
      .reg_bytecount(reg_bytecount),
      .reg_data_in  (reg_data_in),
      .reg_data_out (reg_data_out),
      .reg_read     (reg_read),
      .reg_write    (reg_write),
      .trigger_out  (trigger_out)
   );

   always #5 clkin = ~clkin;

   always @(posedge clkin) cyc <= cyc + 1;

   // Per-cycle monitor: trigger_out against the model, read bus idle when not read.
   always @(negedge clkin) begin
      if (chk_en) begin
         checks++;
         if (trigger_out !== exp_hi[cyc]) begin
            errors++;
            $display("FAIL trig_out cyc=%0d got=%b want=%b", cyc, trigger_out, exp_hi[cyc]);
         end
         if (cyc != rd_label) begin
            checks++;
            if (reg_data_out !== 8'h00) begin
               errors++;
               $display("FAIL rd_idle cyc=%0d got=%h want=00", cyc, reg_data_out);
            end
         end
      end
      if (trigger_out === 1'b1 && !prev_to) pcount++;
      prev_to = (trigger_out === 1'b1);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   function automatic int imax1(input longint v);
      return (v == 0) ? 1 : int'(v);
   endfunction

   function automatic int num_eff(input int v);
      if (v == 0) return 1;
      if (v > 4) return 4;
      return v;
   endfunction

   function automatic logic [7:0] rbv(input logic [7:0] v);
      return RB ? v : 8'h00;
   endfunction

   task automatic model_reset();
      m_num = 1;
      for (int i = 0; i < 4; i++) begin
         m_delay[i] = 0;
         m_width[i] = 0;
      end
   endtask

   task automatic set_exp(input int t);
      if (t >= 0 && t < MAXC) exp_hi[t] = 1'b1;
   endtask

   task automatic clear_exp(input int from);
      for (int t = from; t < MAXC; t++) exp_hi[t] = 1'b0;
   endtask

   // Train model: the first pulse starts 3+DELAY[0] cycles after edge t0.
   // Each pulse lasts max(W,1) cycles; later gaps last max(D,1) cycles.
   task automatic plan_train(input int t0);
      int t;
      t = t0 + 3 + int'(m_delay[0]);
      for (int i = 0; i < m_num; i++) begin
         if (i > 0) t += imax1(m_delay[i]);
         for (int k = 0; k < imax1(m_width[i]); k++) begin
            set_exp(t);
            t++;
         end
      end
   endtask

   task automatic wait_until(input int lbl);
      while (cyc < lbl) @(negedge clkin);
   endtask

   task automatic wr(input logic [7:0] cmd, input logic [15:0] bc, input logic [7:0] d);
      @(negedge clkin);
      reg_cmd = cmd; reg_bytecount = bc; reg_data_in = d; reg_write = 1'b1;
      @(negedge clkin);
      reg_write = 1'b0;
   endtask

   task automatic wr_abort(input logic [7:0] d);
      @(negedge clkin);
      reg_cmd = 8'h20; reg_bytecount = 16'h0; reg_data_in = d; reg_write = 1'b1;
      clear_exp(cyc + 1);
      @(negedge clkin);
      reg_write = 1'b0;
   endtask

   task automatic wr_tab(input logic [7:0] cmd, input int e, input logic [31:0] v);
      for (int b = 0; b < 4; b++) wr(cmd, 16'(e * 4 + b), v[b*8 +: 8]);
   endtask

   task automatic rd_chk(input logic [7:0] cmd, input logic [15:0] bc,
                         input logic [7:0] want, input string nm);
      @(negedge clkin);
      reg_cmd = cmd; reg_bytecount = bc; reg_read = 1'b1;
      rd_label = cyc + 1;
      @(negedge clkin);
      reg_read = 1'b0;
      checks++;
      if (reg_data_out !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, reg_data_out, want);
      end
   endtask

   task automatic chk_bit(input string nm, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%b want=%b", nm, got, want);
      end
   endtask

   task automatic chk_int(input string nm, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", nm, got, want);
      end
   endtask

   // One-cycle trigger_in pulse. The edge counts as cycle 0 = t0.
   task automatic fire(input bit plan, output int t0);
      @(negedge clkin);
      trigger_in = 1'b1;
      t0 = cyc + 1;
      if (plan) plan_train(t0);
      @(negedge clkin);
      trigger_in = 1'b0;
   endtask

   initial begin
      int t0, t1;
      logic [7:0] b4 [4];
      b4[0] = 8'h78; b4[1] = 8'h56; b4[2] = 8'h34; b4[3] = 8'h12;
      for (int i = 0; i < MAXC; i++) exp_hi[i] = 1'b0;
      model_reset();
      repeat (3) @(negedge clkin);
      reset = 1'b0;
      chk_en = 1'b1;

      // Reset state
      chk_bit("reset_trig", trigger_out, 1'b0);
      rd_chk(8'h20, 16'd0, 8'h00, "reset_status");
      rd_chk(8'h21, 16'd0, rbv(8'h01), "reset_num");
      rd_chk(8'h23, 16'd0, 8'h00, "reset_width0");

      // Single pulse: D0=5, W0=3 -> high on cycles 8..10
      wr(8'h21, 16'd0, 8'd1); m_num = 1;
      wr(8'h22, 16'd0, 8'd5); m_delay[0] = 5;
      wr(8'h23, 16'd0, 8'd3); m_width[0] = 3;
      wr(8'h20, 16'd0, 8'h01);
      rd_chk(8'h20, 16'd0, 8'h01, "arm_status");
      fire(1'b1, t0);
      for (int k = 1; k <= 14; k++) begin
         wait_until(t0 + k);
         chk_bit($sformatf("single_k%0d", k), trigger_out, (k >= 8 && k <= 10));
      end
      rd_chk(8'h20, 16'd0, 8'h04, "single_status");

      // Multi-pulse: NUM=3 D={0,0,4} W={1,2,0} -> high on 3,5,6,11
      wr(8'h21, 16'd0, 8'd3); m_num = 3;
      wr_tab(8'h22, 0, 32'd0); m_delay[0] = 0;
      wr_tab(8'h22, 1, 32'd0); m_delay[1] = 0;
      wr_tab(8'h22, 2, 32'd4); m_delay[2] = 4;
      wr_tab(8'h23, 0, 32'd1); m_width[0] = 1;
      wr_tab(8'h23, 1, 32'd2); m_width[1] = 2;
      wr_tab(8'h23, 2, 32'd0); m_width[2] = 0;
      wr(8'h20, 16'd0, 8'h01);
      rd_chk(8'h20, 16'd0, 8'h01, "rearm_clears_done");
      fire(1'b1, t0);
      for (int k = 1; k <= 14; k++) begin
         wait_until(t0 + k);
         chk_bit($sformatf("multi_k%0d", k), trigger_out,
                 (k == 3 || k == 5 || k == 6 || k == 11));
      end
      rd_chk(8'h20, 16'd0, 8'h24, "multi_status");

      // Abort during PULSE, then ARM+ABORT collision
      wr(8'h21, 16'd0, 8'd1); m_num = 1;
      wr_tab(8'h22, 0, 32'd2); m_delay[0] = 2;
      wr_tab(8'h23, 0, 32'd20); m_width[0] = 20;
      wr(8'h20, 16'd0, 8'h01);
      fire(1'b1, t0);
      wait_until(t0 + 8);
      chk_bit("abort_pre_high", trigger_out, 1'b1);
      wr_abort(8'h02);
      chk_bit("abort_low_next", trigger_out, 1'b0);
      rd_chk(8'h20, 16'd0, 8'h00, "abort_status");
      wr(8'h20, 16'd0, 8'h03);
      rd_chk(8'h20, 16'd0, 8'h00, "arm_abort_status");
      fire(1'b0, t0);
      repeat (20) @(negedge clkin);
      rd_chk(8'h20, 16'd0, 8'h00, "idle_edge_ignored");

      // AUTO_REARM with an extra edge during DELAY
      wr(8'h21, 16'd0, 8'd2); m_num = 2;
      wr_tab(8'h22, 0, 32'd3); m_delay[0] = 3;
      wr_tab(8'h22, 1, 32'd2); m_delay[1] = 2;
      wr_tab(8'h23, 0, 32'd2); m_width[0] = 2;
      wr_tab(8'h23, 1, 32'd1); m_width[1] = 1;
      wr(8'h20, 16'd0, 8'h05);
      rd_chk(8'h20, 16'd0, 8'h01, "auto_armed");
      pcount = 0;
      fire(1'b1, t0);
      @(negedge clkin);
      trigger_in = 1'b1;
      wait_until(t0 + 7);
      chk_bit("auto_first_high", trigger_out, 1'b1);
      trigger_in = 1'b0;
      wait_until(t0 + 100);
      fire(1'b1, t1);
      wait_until(t1 + 30);
      chk_int("auto_pulse_count", pcount, 4);
      rd_chk(8'h20, 16'd0, 8'h05, "auto_end_status");
      wr(8'h20, 16'd0, 8'h02);
      rd_chk(8'h20, 16'd0, 8'h04, "auto_off_status");

      // Register access: byte lanes, out-of-range entry, busy writes, NUM clamp
      wr_tab(8'h22, 1, 32'h12345678); m_delay[1] = 64'h12345678;
      for (int b = 0; b < 4; b++)
         rd_chk(8'h22, 16'(4 + b), rbv(b4[b]), $sformatf("delay1_b%0d", b));
      wr(8'h22, 16'd16, 8'hAA);
      rd_chk(8'h22, 16'd16, 8'h00, "oor_entry_read");
      rd_chk(8'h22, 16'd0, rbv(8'h03), "oor_no_alias");
      wr(8'h21, 16'd0, 8'd1); m_num = 1;
      wr_tab(8'h22, 0, 32'd0); m_delay[0] = 0;
      wr_tab(8'h23, 0, 32'd40); m_width[0] = 40;
      wr(8'h20, 16'd0, 8'h01);
      fire(1'b1, t0);
      wait_until(t0 + 10);
      wr(8'h22, 16'd4, 8'hEE);
      wr(8'h21, 16'd0, 8'd3);
      wait_until(t0 + 50);
      rd_chk(8'h22, 16'd4, rbv(8'h78), "busy_write_delay");
      rd_chk(8'h21, 16'd0, rbv(8'h01), "busy_write_num");
      rd_chk(8'h20, 16'd0, 8'h04, "busy_done_status");
      wr(8'h21, 16'd0, 8'd20); m_num = num_eff(20);
      rd_chk(8'h21, 16'd0, rbv(8'h04), "num_clamp_hi");
      wr(8'h21, 16'd0, 8'd0); m_num = num_eff(0);
      rd_chk(8'h21, 16'd0, rbv(8'h01), "num_clamp_zero");
      rd_chk(8'h23, 16'd0, rbv(8'd40), "width0_read");
      rd_chk(8'h24, 16'd0, 8'h00, "unaddr_above");
      rd_chk(8'h1F, 16'd0, 8'h00, "unaddr_below");

      // Mid-train reset during the delay before the second pulse
      wr(8'h21, 16'd0, 8'd3); m_num = 3;
      wr_tab(8'h22, 0, 32'd2); m_delay[0] = 2;
      wr_tab(8'h22, 1, 32'd6); m_delay[1] = 6;
      wr_tab(8'h22, 2, 32'd1); m_delay[2] = 1;
      wr_tab(8'h23, 0, 32'd2); m_width[0] = 2;
      wr_tab(8'h23, 1, 32'd2); m_width[1] = 2;
      wr_tab(8'h23, 2, 32'd2); m_width[2] = 2;
      wr(8'h20, 16'd0, 8'h05);
      fire(1'b1, t0);
      wait_until(t0 + 6);
      chk_bit("rst_pulse0_high", trigger_out, 1'b1);
      wait_until(t0 + 8);
      reset = 1'b1;
      clear_exp(t0 + 9);
      model_reset();
      @(negedge clkin);
      @(negedge clkin);
      reset = 1'b0;
      rd_chk(8'h20, 16'd0, 8'h00, "rst_status");
      rd_chk(8'h21, 16'd0, rbv(8'h01), "rst_num");
      rd_chk(8'h22, 16'd4, 8'h00, "rst_delay1");
      rd_chk(8'h23, 16'd0, 8'h00, "rst_width0");
      repeat (30) @(negedge clkin);
      wr(8'h20, 16'd0, 8'h01);
      fire(1'b1, t0);
      wait_until(t0 + 3);
      chk_bit("rst_default_pulse", trigger_out, 1'b1);
      wait_until(t0 + 12);
      rd_chk(8'h20, 16'd0, 8'h04, "rst_autorearm_off");

      repeat (5) @(negedge clkin);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
